// File: rtl/io_in_pkg.sv
// Shared register map, status-field layout and default sizing for the
// memory-mapped input peripheral.
package io_in_pkg;

  localparam int SW_W_DEF      = 10;
  localparam int BTN_W_DEF     = 4;
  localparam int DB_CYCLES_DEF = 16;

  // Register select, taken from byte-address bits [3:2].
  typedef enum logic [1:0] {
    IO_IN_SW   = 2'd0,
    IO_IN_BTN  = 2'd1,
    IO_IN_EVT  = 2'd2,
    IO_IN_STAT = 2'd3
  } io_in_reg_e;

  localparam int STAT_IRQ_BIT   = 0;
  localparam int STAT_BTNW_LSB  = 8;
  localparam int STAT_BTNW_MSB  = 15;

endpackage

// File: rtl/debounce_1bit.sv
// One button: two-flop synchronizer, run-length debounce counter and
// accepted level, plus a strobe on the edge where the level is accepted high.
module debounce_1bit
  import io_in_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // High during the cycle whose closing edge flips the accepted level.
  assign accept = (sync != stable) && (cnt == CNT_MAX);

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= i_pin;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_level = stable;
  assign o_rise  = accept & sync;

endmodule

// File: rtl/io_input_reader.sv
// Input peripheral on the LSU load path: synchronized switches, debounced
// buttons, sticky clear-on-read press events and a combinational read mux.
module io_input_reader
  import io_in_pkg::*;
#(
  parameter int SW_W      = SW_W_DEF,
  parameter int BTN_W     = BTN_W_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_W-1:0] i_io_btn,
  input  logic             i_rd_en,
  input  logic [3:0]       i_addr,
  output logic [31:0]      o_rdata,
  output logic             o_irq
);

  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [BTN_W-1:0] btn_level;
  logic [BTN_W-1:0] btn_rise;
  logic [BTN_W-1:0] events;
  io_in_reg_e       sel;
  logic             evt_clear;
  logic             unused_addr_bits;

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    debounce_1bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_pin   (i_io_btn[g]),
      .o_level (btn_level[g]),
      .o_rise  (btn_rise[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= i_io_sw;
      sw_sync <= sw_meta;
    end
  end

  assign sel              = io_in_reg_e'(i_addr[3:2]);
  assign evt_clear        = i_rd_en && (sel == IO_IN_EVT);
  assign unused_addr_bits = ^i_addr[1:0];

  // A press landing on the clearing edge replaces the cleared value, so it survives.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      events <= '0;
    end else if (evt_clear) begin
      events <= btn_rise;
    end else begin
      events <= events | btn_rise;
    end
  end

  assign o_irq = |events;

  // NOTE: o_rdata gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_rdata = '0;
    if (i_rd_en) begin
      case (sel)
        IO_IN_SW:   o_rdata[SW_W-1:0]  = sw_sync;
        IO_IN_BTN:  o_rdata[BTN_W-1:0] = btn_level;
        IO_IN_EVT:  o_rdata[BTN_W-1:0] = events;
        IO_IN_STAT: begin
          o_rdata[STAT_IRQ_BIT]                 = o_irq;
          o_rdata[STAT_BTNW_MSB:STAT_BTNW_LSB] = 8'(BTN_W);
        end
        default:    o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_reader.sv
// Bench for io_input_reader: directed vector table with hand-derived
// expectations, then randomized traffic against a sample-window model.
module tb_io_input_reader;
  import io_in_pkg::*;

  localparam int SW_W  = 10;
  localparam int BTN_W = 4;
  localparam int DB    = 4;

  localparam logic [3:0] A_SW   = 4'h0;
  localparam logic [3:0] A_BTN  = 4'h5;
  localparam logic [3:0] A_EVT  = 4'hB;
  localparam logic [3:0] A_STAT = 4'hE;

  logic             clk = 1'b0;
  logic             reset;
  logic [SW_W-1:0]  io_sw;
  logic [BTN_W-1:0] io_btn;
  logic             rd_en;
  logic [3:0]       addr;
  logic [31:0]      rdata;
  logic             irq;

  always #5 clk = ~clk;

  io_input_reader #(
    .SW_W      (SW_W),
    .BTN_W     (BTN_W),
    .DB_CYCLES (DB)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_io_sw  (io_sw),
    .i_io_btn (io_btn),
    .i_rd_en  (rd_en),
    .i_addr   (addr),
    .o_rdata  (rdata),
    .o_irq    (irq)
  );

  typedef struct {
    logic             rst;
    logic [BTN_W-1:0] btn;
    logic [SW_W-1:0]  sw;
    logic             rd;
    logic [3:0]       addr;
    logic [31:0]      exp_rdata;
    logic             exp_irq;
    logic             chk;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: pin -> two-stage delay -> accept a new level once the
  // last DB synchronized samples all disagree with the current level.
  logic [SW_W-1:0]  m_sw1    = '0;
  logic [SW_W-1:0]  m_sw2    = '0;
  logic [BTN_W-1:0] m_btn1   = '0;
  logic [BTN_W-1:0] m_sync   = '0;
  logic [BTN_W-1:0] m_stable = '0;
  logic [BTN_W-1:0] m_evt    = '0;
  logic [DB-1:0]    m_hist [BTN_W];

  task automatic model_edge();
    logic [BTN_W-1:0] press;
    press = '0;
    if (reset) begin
      m_sw1 = '0; m_sw2 = '0; m_btn1 = '0; m_sync = '0;
      m_stable = '0; m_evt = '0;
      for (int b = 0; b < BTN_W; b++) m_hist[b] = '0;
    end else begin
      for (int b = 0; b < BTN_W; b++) begin
        m_hist[b] = {m_hist[b][DB-2:0], m_sync[b]};
        if (m_hist[b] == {DB{~m_stable[b]}}) begin
          m_stable[b] = ~m_stable[b];
          press[b]    = m_stable[b];
        end
      end
      if (rd_en && addr[3:2] == 2'd2) m_evt = press;
      else                            m_evt = m_evt | press;
      m_sync = m_btn1;
      m_btn1 = io_btn;
      m_sw2  = m_sw1;
      m_sw1  = io_sw;
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic rd, input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (rd) begin
      case (a[3:2])
        2'd0: r[SW_W-1:0]  = m_sw2;
        2'd1: r[BTN_W-1:0] = m_stable;
        2'd2: r[BTN_W-1:0] = m_evt;
        default: begin
          r[0]    = |m_evt;
          r[15:8] = 8'(BTN_W);
        end
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance past one posedge.
  task automatic step(input vec_t v, input logic use_model, input string name);
    reset  = v.rst;
    io_btn = v.btn;
    io_sw  = v.sw;
    rd_en  = v.rd;
    addr   = v.addr;
    #1;
    if (use_model) begin
      check({name, " rdata"}, rdata, model_rdata(v.rd, v.addr));
      check({name, " irq"}, {31'b0, irq}, {31'b0, |m_evt});
    end else if (v.chk) begin
      check({name, " rdata"}, rdata, v.exp_rdata);
      check({name, " irq"}, {31'b0, irq}, {31'b0, v.exp_irq});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic add(input int n, input logic rst, input logic [BTN_W-1:0] btn,
                     input logic rd, input logic [3:0] a, input logic [31:0] exp,
                     input logic exp_irq, input logic chk);
    vec_t v;
    v.rst = rst; v.btn = btn; v.sw = 10'h3FF; v.rd = rd; v.addr = a;
    v.exp_rdata = exp; v.exp_irq = exp_irq; v.chk = chk;
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    logic [BTN_W-1:0] cur_btn;
    logic [SW_W-1:0]  cur_sw;

    for (int b = 0; b < BTN_W; b++) m_hist[b] = '0;

    // Reset with all pins high: everything reads 0.
    add(1, 1, 4'hF, 0, A_SW,  0, 0, 0);
    add(1, 1, 4'hF, 1, A_SW,  0, 0, 1);
    add(1, 1, 4'hF, 1, A_EVT, 0, 0, 1);
    add(1, 1, 4'hF, 1, A_BTN, 0, 0, 1);
    // Release: switches after two edges, buttons accepted on edge 2+DB.
    add(1, 0, 4'hF, 1, A_SW,   0,      0, 1);
    add(1, 0, 4'hF, 1, A_SW,   0,      0, 1);
    add(1, 0, 4'hF, 1, A_SW,   'h3FF,  0, 1);
    add(1, 0, 4'hF, 1, A_BTN,  0,      0, 1);
    add(1, 0, 4'hF, 1, A_EVT,  0,      0, 1);
    add(1, 0, 4'hF, 1, A_EVT,  0,      0, 1);
    add(1, 0, 4'hF, 0, A_SW,   0,      1, 1);
    add(1, 0, 4'hF, 1, A_BTN,  'hF,    1, 1);
    add(1, 0, 4'hF, 1, A_STAT, 'h401,  1, 1);
    add(1, 0, 4'hF, 1, A_EVT,  'hF,    1, 1);
    add(1, 0, 4'hF, 1, A_EVT,  0,      0, 1);
    // Release all: level drops after DB samples, no event.
    add(1, 0, 4'h0, 1, A_BTN, 'hF, 0, 1);
    add(5, 0, 4'h0, 0, A_SW,  0,   0, 1);
    add(1, 0, 4'h0, 1, A_BTN, 0,   0, 1);
    add(1, 0, 4'h0, 1, A_EVT, 0,   0, 1);
    // Button 1 glitch of 3 samples is ignored.
    add(3, 0, 4'h2, 0, A_SW,  0, 0, 1);
    add(8, 0, 4'h0, 0, A_SW,  0, 0, 1);
    add(1, 0, 4'h0, 1, A_BTN, 0, 0, 1);
    add(1, 0, 4'h0, 1, A_EVT, 0, 0, 1);
    // Button 3 press, release, press without a read: one sticky bit.
    add(8, 0, 4'h8, 0, A_SW,  0,   0, 0);
    add(8, 0, 4'h0, 0, A_SW,  0,   0, 0);
    add(8, 0, 4'h8, 0, A_SW,  0,   0, 0);
    add(1, 0, 4'h8, 1, A_EVT, 'h8, 1, 1);
    add(1, 0, 4'h8, 1, A_BTN, 'h8, 0, 1);
    // Events 0x5 pending and button 1 mid-count, then reset.
    add(8, 0, 4'hD, 0, A_SW,   0,     0, 0);
    add(1, 0, 4'hD, 1, A_STAT, 'h401, 1, 1);
    add(1, 0, 4'hD, 1, A_BTN,  'hD,   1, 1);
    add(4, 0, 4'hF, 0, A_SW,   0,     0, 0);
    add(1, 1, 4'hF, 0, A_SW,   0,     0, 0);
    add(1, 0, 4'hF, 1, A_EVT,  0,     0, 1);
    add(1, 0, 4'hF, 1, A_BTN,  0,     0, 1);
    add(3, 0, 4'hF, 0, A_SW,   0,     0, 1);
    add(1, 0, 4'hF, 1, A_BTN,  0,     0, 1);
    add(1, 0, 4'hF, 1, A_BTN,  'hF,   1, 1);
    add(1, 0, 4'hF, 1, A_EVT,  'hF,   1, 1);
    add(1, 0, 4'hF, 1, A_EVT,  0,     0, 1);
    // Button 2 accepted on the same edge as a clearing read.
    add(8, 0, 4'h0, 0, A_SW,  0,   0, 1);
    add(5, 0, 4'h4, 0, A_SW,  0,   0, 1);
    add(1, 0, 4'h4, 1, A_EVT, 0,   0, 1);
    add(1, 0, 4'h4, 1, A_EVT, 'h4, 1, 1);
    add(1, 0, 4'h4, 1, A_EVT, 0,   0, 1);

    foreach (tbl[i]) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Randomized traffic against the model; buttons toggle rarely so that
    // both accepted changes and short glitches occur.
    cur_btn = '0;
    cur_sw  = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < BTN_W; b++)
        if ($urandom_range(9) == 0) cur_btn[b] = ~cur_btn[b];
      if ($urandom_range(7) == 0) cur_sw = SW_W'($urandom);
      v.rst  = (n == 0) || ($urandom_range(299) == 0);
      v.btn  = cur_btn;
      v.sw   = cur_sw;
      v.rd   = 1'($urandom_range(1));
      v.addr = 4'($urandom_range(15));
      v.exp_rdata = '0;
      v.exp_irq   = 1'b0;
      v.chk       = 1'b1;
      step(v, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
